// File: rtl/bsg_manycore_link_sif_edge_responder_pkg.sv
// rtl/bsg_manycore_link_sif_edge_responder_pkg.sv - manycore packet constants and link width helpers
package bsg_manycore_link_sif_edge_responder_pkg;

    localparam int packet_op_width_lp       = 2;
    localparam int packet_op_ex_width_lp    = 4;
    localparam int packet_reg_id_width_lp   = 5;
    localparam int return_pkt_type_width_lp = 2;

    typedef enum logic [packet_op_width_lp-1:0] {
        e_remote_load  = 2'd0,
        e_remote_store = 2'd1,
        e_remote_amo   = 2'd2,
        e_cache_op     = 2'd3
    } packet_op_e;

    typedef enum logic [return_pkt_type_width_lp-1:0] {
        ePacketType_credit = 2'd0,
        ePacketType_data   = 2'd1,
        ePacketType_ifetch = 2'd2,
        ePacketType_float  = 2'd3
    } return_packet_type_e;

    // Forward packet: addr, op, op_ex, reg_id, payload, src_y, src_x, y, x.
    function automatic int packet_width(input int addr_w, input int data_w,
                                        input int x_w, input int y_w);
        return addr_w + packet_op_width_lp + packet_op_ex_width_lp
             + packet_reg_id_width_lp + data_w + 2 * (x_w + y_w);
    endfunction

    // Return packet: pkt_type, data, load_id, y, x.
    function automatic int return_packet_width(input int data_w, input int x_w,
                                               input int y_w, input int load_id_w);
        return return_pkt_type_width_lp + data_w + load_id_w + x_w + y_w;
    endfunction

    // Each direction carries a valid and a ready alongside its packet.
    function automatic int link_sif_width(input int addr_w, input int data_w, input int x_w,
                                          input int y_w, input int load_id_w);
        return 4 + packet_width(addr_w, data_w, x_w, y_w)
                 + return_packet_width(data_w, x_w, y_w, load_id_w);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small ready/valid FIFO with registered full and no bypass
module bsg_fifo_1r1w_small
    import bsg_manycore_link_sif_edge_responder_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_param_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int count_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]        r_mem [els_p];
    logic [ptr_width_lp-1:0]   r_wr_ptr;
    logic [ptr_width_lp-1:0]   r_rd_ptr;
    logic [count_width_lp-1:0] r_count;
    logic                      w_enq;
    logic                      w_deq;

    // Status comes only from the registered count, so a dequeue never frees a slot early
    // and an enqueue into an empty FIFO is not visible until the next cycle.
    assign ready_param_o = (r_count != count_width_lp'(els_p));
    assign v_o           = (r_count != '0);
    assign data_o        = r_mem[r_rd_ptr];
    assign w_enq         = v_i & ready_param_o;
    assign w_deq         = yumi_i & v_o;

    // Storage write; contents need no reset because v_o gates their use.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; reset drops every stored entry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= (r_wr_ptr == ptr_width_lp'(els_p - 1)) ? '0 : r_wr_ptr + ptr_width_lp'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= (r_rd_ptr == ptr_width_lp'(els_p - 1)) ? '0 : r_rd_ptr + ptr_width_lp'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + count_width_lp'(1);
                2'b01:   r_count <= r_count - count_width_lp'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bsg_manycore_link_sif_edge_responder.sv
// rtl/bsg_manycore_link_sif_edge_responder.sv - buffered mesh edge terminator returning one credit per packet
module bsg_manycore_link_sif_edge_responder
    import bsg_manycore_link_sif_edge_responder_pkg::*;
#(
    parameter int addr_width_p    = 32,
    parameter int data_width_p    = 32,
    parameter int x_cord_width_p  = 4,
    parameter int y_cord_width_p  = 3,
    parameter int load_id_width_p = 5,
    parameter int fifo_els_p      = 2,
    parameter int count_width_p   = 16,
    parameter bit error_report_p  = 1'b1,
    localparam int bsg_manycore_link_sif_width_lp =
        link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p, load_id_width_p)
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [bsg_manycore_link_sif_width_lp-1:0] link_sif_i,
    output logic [bsg_manycore_link_sif_width_lp-1:0] link_sif_o,
    output logic [count_width_p-1:0]                  fwd_count_o,
    output logic [count_width_p-1:0]                  rev_count_o,
    output logic                                      first_v_o,
    output logic [addr_width_p-1:0]                   first_addr_o,
    output logic [x_cord_width_p-1:0]                 first_src_x_o,
    output logic [y_cord_width_p-1:0]                 first_src_y_o
);

    if (fifo_els_p < 2) begin : g_bad_fifo_els
        $error("fifo_els_p must be at least 2");
    end

    typedef struct packed {
        logic [addr_width_p-1:0]           addr;
        packet_op_e                        op;
        logic [packet_op_ex_width_lp-1:0]  op_ex;
        logic [packet_reg_id_width_lp-1:0] reg_id;
        logic [data_width_p-1:0]           payload;
        logic [y_cord_width_p-1:0]         src_y_cord;
        logic [x_cord_width_p-1:0]         src_x_cord;
        logic [y_cord_width_p-1:0]         y_cord;
        logic [x_cord_width_p-1:0]         x_cord;
    } packet_s;

    typedef struct packed {
        return_packet_type_e        pkt_type;
        logic [data_width_p-1:0]    data;
        logic [load_id_width_p-1:0] load_id;
        logic [y_cord_width_p-1:0]  y_cord;
        logic [x_cord_width_p-1:0]  x_cord;
    } return_packet_s;

    typedef struct packed {
        logic    v;
        packet_s data;
        logic    ready_and_rev;
    } fwd_link_s;

    typedef struct packed {
        logic           v;
        return_packet_s data;
        logic           ready_and_rev;
    } rev_link_s;

    typedef struct packed {
        fwd_link_s fwd;
        rev_link_s rev;
    } link_sif_s;

    localparam int coord_width_lp = x_cord_width_p + y_cord_width_p;

    link_sif_s                    w_link_in;
    link_sif_s                    w_link_out;
    packet_s                      w_fwd_pkt;
    logic                         w_fwd_ready;
    logic                         w_fwd_accept;
    logic                         w_rev_absorb;
    logic                         w_fifo_ready;
    logic                         w_fifo_v;
    logic                         w_fifo_yumi;
    logic [coord_width_lp-1:0]    w_fifo_data_in;
    logic [coord_width_lp-1:0]    w_fifo_data_out;
    logic [count_width_p-1:0]     r_fwd_count;
    logic [count_width_p-1:0]     r_rev_count;
    logic                         r_first_v;
    logic [addr_width_p-1:0]      r_first_addr;
    logic [x_cord_width_p-1:0]    r_first_src_x;
    logic [y_cord_width_p-1:0]    r_first_src_y;
    logic                         w_unused;

    assign w_link_in = link_sif_i;
    assign w_fwd_pkt = w_link_in.fwd.data;

    // Forward side: accept only when a credit slot is free and never during reset.
    assign w_fwd_ready    = ~reset_i & w_fifo_ready;
    assign w_fwd_accept   = w_link_in.fwd.v & w_fwd_ready;
    assign w_fifo_data_in = {w_fwd_pkt.src_x_cord, w_fwd_pkt.src_y_cord};

    // Return side: stray return traffic is always swallowed outside reset.
    assign w_rev_absorb = w_link_in.rev.v & ~reset_i;
    assign w_fifo_yumi  = w_fifo_v & w_link_in.rev.ready_and_rev;

    bsg_fifo_1r1w_small #(
        .width_p (coord_width_lp),
        .els_p   (fifo_els_p)
    ) u_credit_fifo (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .v_i           (w_fwd_accept),
        .ready_param_o (w_fifo_ready),
        .data_i        (w_fifo_data_in),
        .v_o           (w_fifo_v),
        .data_o        (w_fifo_data_out),
        .yumi_i        (w_fifo_yumi)
    );

    // Outgoing link: forward direction is silent, return direction carries the head credit.
    always_comb begin
        w_link_out                   = '0;
        w_link_out.fwd.ready_and_rev = w_fwd_ready;
        w_link_out.rev.v             = w_fifo_v;
        w_link_out.rev.data.pkt_type = ePacketType_credit;
        w_link_out.rev.data.x_cord   = w_fifo_data_out[coord_width_lp-1:y_cord_width_p];
        w_link_out.rev.data.y_cord   = w_fifo_data_out[y_cord_width_p-1:0];
        w_link_out.rev.ready_and_rev = ~reset_i;
    end

    assign link_sif_o = w_link_out;

    // Saturating activity counters; they stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_fwd_count <= '0;
            r_rev_count <= '0;
        end else begin
            if (w_fwd_accept && (r_fwd_count != '1)) begin
                r_fwd_count <= r_fwd_count + count_width_p'(1);
            end
            if (w_rev_absorb && (r_rev_count != '1)) begin
                r_rev_count <= r_rev_count + count_width_p'(1);
            end
        end
    end

    // Sticky capture of the first forward packet seen since reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_first_v     <= 1'b0;
            r_first_addr  <= '0;
            r_first_src_x <= '0;
            r_first_src_y <= '0;
        end else if (w_fwd_accept && !r_first_v) begin
            r_first_v     <= 1'b1;
            r_first_addr  <= w_fwd_pkt.addr;
            r_first_src_x <= w_fwd_pkt.src_x_cord;
            r_first_src_y <= w_fwd_pkt.src_y_cord;
        end
    end

    // Simulation-time alarm: traffic reaching the array edge usually means a routing bug.
    always_ff @(posedge clk_i) begin
        if (error_report_p && !reset_i) begin
            if (w_fwd_accept) begin
                $error("edge responder: forward packet addr=%h from x=%0d y=%0d",
                       w_fwd_pkt.addr, w_fwd_pkt.src_x_cord, w_fwd_pkt.src_y_cord);
            end
            if (w_rev_absorb) begin
                $error("edge responder: stray return packet absorbed");
            end
        end
    end

    assign fwd_count_o   = r_fwd_count;
    assign rev_count_o   = r_rev_count;
    assign first_v_o     = r_first_v;
    assign first_addr_o  = r_first_addr;
    assign first_src_x_o = r_first_src_x;
    assign first_src_y_o = r_first_src_y;

    assign w_unused = ^{w_link_in.fwd.ready_and_rev, w_link_in.rev.data, w_fwd_pkt.op,
                        w_fwd_pkt.op_ex, w_fwd_pkt.reg_id, w_fwd_pkt.payload,
                        w_fwd_pkt.y_cord, w_fwd_pkt.x_cord};

endmodule

// File: tb/tb_bsg_manycore_link_sif_edge_responder.sv
// tb/tb_bsg_manycore_link_sif_edge_responder.sv - scoreboard bench for the edge responder
module tb_bsg_manycore_link_sif_edge_responder;
    import bsg_manycore_link_sif_edge_responder_pkg::*;

    localparam int aw  = 32;
    localparam int dw  = 32;
    localparam int xw  = 4;
    localparam int yw  = 3;
    localparam int lw  = 5;
    localparam int els = 2;
    localparam int cw  = 4;
    localparam int lsw = link_sif_width(aw, dw, xw, yw, lw);
    localparam logic [cw-1:0] cmax = '1;

    typedef struct packed {
        logic [aw-1:0] addr;
        packet_op_e    op;
        logic [3:0]    op_ex;
        logic [4:0]    reg_id;
        logic [dw-1:0] payload;
        logic [yw-1:0] src_y_cord;
        logic [xw-1:0] src_x_cord;
        logic [yw-1:0] y_cord;
        logic [xw-1:0] x_cord;
    } packet_s;

    typedef struct packed {
        return_packet_type_e pkt_type;
        logic [dw-1:0]       data;
        logic [lw-1:0]       load_id;
        logic [yw-1:0]       y_cord;
        logic [xw-1:0]       x_cord;
    } return_packet_s;

    typedef struct packed { logic v; packet_s data; logic ready_and_rev; } fwd_link_s;
    typedef struct packed { logic v; return_packet_s data; logic ready_and_rev; } rev_link_s;
    typedef struct packed { fwd_link_s fwd; rev_link_s rev; } link_sif_s;

    logic           clk = 1'b0;
    logic           reset;
    link_sif_s      tb_in;
    link_sif_s      dut_out;
    logic [lsw-1:0] link_sif_i;
    logic [lsw-1:0] link_sif_o;
    logic [cw-1:0]  fwd_count;
    logic [cw-1:0]  rev_count;
    logic           first_v;
    logic [aw-1:0]  first_addr;
    logic [xw-1:0]  first_x;
    logic [yw-1:0]  first_y;

    assign link_sif_i = tb_in;
    assign dut_out    = link_sif_o;

    bsg_manycore_link_sif_edge_responder #(
        .addr_width_p    (aw),
        .data_width_p    (dw),
        .x_cord_width_p  (xw),
        .y_cord_width_p  (yw),
        .load_id_width_p (lw),
        .fifo_els_p      (els),
        .count_width_p   (cw),
        .error_report_p  (1'b0)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .link_sif_i    (link_sif_i),
        .link_sif_o    (link_sif_o),
        .fwd_count_o   (fwd_count),
        .rev_count_o   (rev_count),
        .first_v_o     (first_v),
        .first_addr_o  (first_addr),
        .first_src_x_o (first_x),
        .first_src_y_o (first_y)
    );

    always #5 clk = ~clk;

    int n_vectors    = 0;
    int n_miscompares = 0;

    // Reference model: credit queue holds {src_x, src_y} in arrival order.
    logic [xw+yw-1:0] sb[$];
    logic [cw-1:0]    m_fwd;
    logic [cw-1:0]    m_rev;
    logic             m_first_v;
    logic [aw-1:0]    m_first_addr;
    logic [xw-1:0]    m_first_x;
    logic [yw-1:0]    m_first_y;
    logic             m_acc;
    int               m_popped;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_fwd(input logic v, input logic [aw-1:0] addr,
                             input logic [xw-1:0] x, input logic [yw-1:0] y);
        tb_in.fwd.v               = v;
        tb_in.fwd.data.addr       = addr;
        tb_in.fwd.data.op         = e_remote_store;
        tb_in.fwd.data.payload    = $urandom;
        tb_in.fwd.data.src_x_cord = x;
        tb_in.fwd.data.src_y_cord = y;
        tb_in.fwd.data.x_cord     = xw'($urandom);
        tb_in.fwd.data.y_cord     = yw'($urandom);
    endtask

    // Called just after a negedge with inputs driven: check outputs, advance model, cross one posedge.
    task automatic step();
        logic exp_ready;
        logic deq;
        #1;
        exp_ready = !reset && (sb.size() < els);
        check_eq("fwd_ready", 64'(dut_out.fwd.ready_and_rev), 64'(exp_ready));
        check_eq("rev_ready", 64'(dut_out.rev.ready_and_rev), 64'(!reset));
        check_eq("fwd_out_idle", 64'({dut_out.fwd.v, (dut_out.fwd.data == '0)}), 64'(2'b01));
        check_eq("rev_v", 64'(dut_out.rev.v), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            check_eq("credit_xy", 64'({dut_out.rev.data.x_cord, dut_out.rev.data.y_cord}), 64'(sb[0]));
            check_eq("credit_type", 64'(dut_out.rev.data.pkt_type), 64'(ePacketType_credit));
            check_eq("credit_data", 64'(dut_out.rev.data.data), 64'(0));
        end
        check_eq("fwd_count", 64'(fwd_count), 64'(m_fwd));
        check_eq("rev_count", 64'(rev_count), 64'(m_rev));
        check_eq("first_v", 64'(first_v), 64'(m_first_v));
        check_eq("first_capture", {first_addr, first_x, first_y}, {m_first_addr, m_first_x, m_first_y});
        m_acc = 1'b0;
        if (reset) begin
            sb.delete();
            m_fwd = '0; m_rev = '0; m_first_v = 1'b0;
            m_first_addr = '0; m_first_x = '0; m_first_y = '0;
        end else begin
            m_acc = tb_in.fwd.v && exp_ready;
            deq   = (sb.size() != 0) && tb_in.rev.ready_and_rev;
            if (deq) begin
                void'(sb.pop_front());
                m_popped++;
            end
            if (m_acc) begin
                sb.push_back({tb_in.fwd.data.src_x_cord, tb_in.fwd.data.src_y_cord});
                if (m_fwd != cmax) m_fwd++;
                if (!m_first_v) begin
                    m_first_v    = 1'b1;
                    m_first_addr = tb_in.fwd.data.addr;
                    m_first_x    = tb_in.fwd.data.src_x_cord;
                    m_first_y    = tb_in.fwd.data.src_y_cord;
                end
            end
            if (tb_in.rev.v && (m_rev != cmax)) m_rev++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int idx;
        logic [xw-1:0] bx [5];
        logic [yw-1:0] by [5];
        bx = '{4'd1, 4'd2, 4'd7, 4'd9, 4'd15};
        by = '{3'd0, 3'd5, 3'd3, 3'd6, 3'd7};
        tb_in = '0;
        m_fwd = '0; m_rev = '0; m_first_v = 1'b0;
        m_first_addr = '0; m_first_x = '0; m_first_y = '0; m_popped = 0;

        // Reset held with a forward packet offered: nothing may be accepted.
        reset = 1'b1;
        drive_fwd(1'b1, 32'h0000_0abc, 4'd6, 3'd2);
        @(negedge clk);
        repeat (3) step();
        reset = 1'b0;
        drive_fwd(1'b0, '0, '0, '0);
        step();

        // Single store from (3,1) at 0x100 with return ready.
        tb_in.rev.ready_and_rev = 1'b1;
        drive_fwd(1'b1, 32'h100, 4'd3, 3'd1);
        step();
        drive_fwd(1'b0, '0, '0, '0);
        #1;
        check_eq("single_rev_v", 64'(dut_out.rev.v), 64'(1));
        check_eq("single_credit_xy", 64'({dut_out.rev.data.x_cord, dut_out.rev.data.y_cord}), 64'({4'd3, 3'd1}));
        check_eq("single_fwd_count", 64'(fwd_count), 64'(1));
        check_eq("single_first_addr", 64'(first_addr), 64'(32'h100));
        step();

        // Second packet must not disturb the capture.
        drive_fwd(1'b1, 32'h200, 4'd5, 3'd2);
        step();
        drive_fwd(1'b0, '0, '0, '0);
        step();
        check_eq("keep_first_addr", 64'(first_addr), 64'(32'h100));
        check_eq("keep_first_v", 64'(first_v), 64'(1));

        // Five back-to-back packets against a stalled return channel, released later.
        idx = 0;
        m_popped = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (idx == 5 && sb.size() == 0) break;
            if (cyc == 6) check_eq("burst_held_accepts", 64'(idx), 64'(2));
            tb_in.rev.ready_and_rev = (cyc >= 6);
            if (idx < 5) drive_fwd(1'b1, 32'h300 + 32'(idx), bx[idx], by[idx]);
            else drive_fwd(1'b0, '0, '0, '0);
            step();
            if (m_acc) idx++;
        end
        check_eq("burst_accepted", 64'(idx), 64'(5));
        check_eq("burst_credits", 64'(m_popped), 64'(5));
        drive_fwd(1'b0, '0, '0, '0);

        // Reset pulse with two credits pending.
        tb_in.rev.ready_and_rev = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_fwd(1'b1, 32'h400 + 32'(i), 4'(i + 10), 3'(i + 4));
            step();
        end
        drive_fwd(1'b0, '0, '0, '0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        tb_in.rev.ready_and_rev = 1'b1;
        #1;
        check_eq("rst_rev_v", 64'(dut_out.rev.v), 64'(0));
        check_eq("rst_counts", 64'({fwd_count, rev_count}), 64'(0));
        check_eq("rst_first_v", 64'(first_v), 64'(0));
        repeat (4) step();

        // Saturation: 20 forward packets and 17 return packets.
        for (int i = 0; i < 22; i++) begin
            if (i < 20) drive_fwd(1'b1, 32'h1000 + 32'(i), 4'(i), 3'(i));
            else drive_fwd(1'b0, '0, '0, '0);
            tb_in.rev.v = (i < 17);
            step();
        end
        tb_in.rev.v = 1'b0;
        step();
        check_eq("sat_fwd_count", 64'(fwd_count), 64'(15));
        check_eq("sat_rev_count", 64'(rev_count), 64'(15));

        // Random traffic on all three handshakes.
        for (int i = 0; i < 80; i++) begin
            drive_fwd(1'($urandom), $urandom, 4'($urandom), 3'($urandom));
            tb_in.rev.ready_and_rev = ($urandom_range(0, 3) != 0);
            tb_in.rev.v = 1'($urandom);
            step();
        end
        drive_fwd(1'b0, '0, '0, '0);
        tb_in.rev.v = 1'b0;
        tb_in.rev.ready_and_rev = 1'b1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
